// File: rtl/priority_resolver_if.sv
`default_nettype none
// =============================================================================
// priority_resolver_if : IR/IMR/INTA/EOI bundle into the priority stage and the
//                        INT/level/IRR/ISR results back out.
// Revision 1.0
// =============================================================================
interface priority_resolver_if;
  logic [7:0] IR;
  logic [7:0] IMR;
  logic       INTA;
  logic       EOI;
  logic       SEOI;
  logic [2:0] EOILevel;
  logic       INT;
  logic [2:0] highestPriority;
  logic       currentPulse;
  logic [7:0] requestReg;
  logic [7:0] inService;

  modport master (
    output IR, IMR, INTA, EOI, SEOI, EOILevel,
    input  INT, highestPriority, currentPulse, requestReg, inService
  );

  modport slave (
    input  IR, IMR, INTA, EOI, SEOI, EOILevel,
    output INT, highestPriority, currentPulse, requestReg, inService
  );
endinterface
`default_nettype wire

// File: rtl/priority_resolver.sv
`default_nettype none
// =============================================================================
// priority_resolver : 8259A request register, fully nested priority resolver,
//                     INTA two-pulse sequencer and EOI handling.
// Revision 1.0
// =============================================================================
module priority_resolver #(
  parameter bit LEVEL_TRIG = 1'b0,
  parameter bit AUTO_EOI   = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  priority_resolver_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACK1 = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;
  localparam logic [1:0] c_ACK2 = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] ir_prev_q;
  logic       inta_q, inta_prev_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] hp_q, hp_d;
  logic       pulse_q, pulse_d;
  logic       int_q, int_d;
  logic       spur_q, spur_d;

  logic       w_fall, w_rise;
  logic [7:0] w_pend;
  logic [2:0] w_cand;
  logic [2:0] w_isr_low;
  logic [7:0] w_isr_low_oh;
  logic       w_valid;
  logic [7:0] w_ack_set;
  logic [7:0] w_auto_clr;
  logic [7:0] w_eoi_clr;
  logic [7:0] w_ir_req;

  // INTA is registered once more so edges are seen from a clean two-stage history.
  assign w_fall = inta_prev_q & ~inta_q;
  assign w_rise = ~inta_prev_q & inta_q;
  assign w_pend = irr_q & ~bus.IMR;

  always_comb begin
    w_cand = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_pend[i]) w_cand = 3'(i);
    end
  end

  always_comb begin
    w_isr_low    = 3'd0;
    w_isr_low_oh = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (isr_q[i]) begin
        w_isr_low    = 3'(i);
        w_isr_low_oh = 8'(1) << i;
      end
    end
  end

  // A request only interrupts when it outranks everything already in service.
  assign w_valid = (w_pend != 8'h00) && ((isr_q == 8'h00) || (w_cand < w_isr_low));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_fall) state_d = c_ACK1;
      c_ACK1:  if (w_rise) state_d = c_GAP;
      c_GAP:   if (w_fall) state_d = c_ACK2;
      c_ACK2:  if (w_rise) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // ----------------------------------------------------------- outputs / data
  always_comb begin
    hp_d       = hp_q;
    pulse_d    = pulse_q;
    int_d      = 1'b0;
    spur_d     = spur_q;
    w_ack_set  = 8'h00;
    w_auto_clr = 8'h00;
    case (state_q)
      c_IDLE: begin
        int_d = w_valid;
        hp_d  = w_cand;
        if (w_fall) begin
          int_d = 1'b0;
          if (w_valid) begin
            hp_d              = w_cand;
            w_ack_set[w_cand] = 1'b1;
            spur_d            = 1'b0;
          end else begin
            hp_d   = 3'd7;
            spur_d = 1'b1;
          end
        end
      end
      c_ACK1: begin
        if (w_rise) pulse_d = 1'b1;
      end
      c_GAP: begin
        pulse_d = pulse_q;
      end
      c_ACK2: begin
        if (w_rise) begin
          pulse_d = 1'b0;
          if (AUTO_EOI && !spur_q) w_auto_clr[hp_q] = 1'b1;
        end
      end
      default: begin
        pulse_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_eoi_clr = 8'h00;
    if (bus.EOI) begin
      if (bus.SEOI) w_eoi_clr[bus.EOILevel] = 1'b1;
      else          w_eoi_clr = w_isr_low_oh;
    end
  end

  // The acknowledge clear beats a new request; the acknowledge set beats EOI.
  assign w_ir_req = LEVEL_TRIG ? bus.IR : (irr_q | (bus.IR & ~ir_prev_q));
  assign irr_d    = w_ir_req & ~w_ack_set;
  assign isr_d    = (isr_q & ~w_eoi_clr & ~w_auto_clr) | w_ack_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_prev_q   <= 8'h00;
      inta_q      <= 1'b1;
      inta_prev_q <= 1'b1;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      hp_q        <= 3'd0;
      pulse_q     <= 1'b0;
      int_q       <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      ir_prev_q   <= bus.IR;
      inta_q      <= bus.INTA;
      inta_prev_q <= inta_q;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      hp_q        <= hp_d;
      pulse_q     <= pulse_d;
      int_q       <= int_d;
      spur_q      <= spur_d;
    end
  end

  assign bus.INT             = int_q;
  assign bus.highestPriority = hp_q;
  assign bus.currentPulse    = pulse_q;
  assign bus.requestReg      = irr_q;
  assign bus.inService       = isr_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_resolver.sv
`default_nettype none
// =============================================================================
// tb_priority_resolver : directed checks of the edge-mode resolver and an
//                        AUTO_EOI instance.
// Revision 1.0
// =============================================================================
module tb_priority_resolver;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  priority_resolver_if bus  ();
  priority_resolver_if bus2 ();

  priority_resolver #(.LEVEL_TRIG(1'b0), .AUTO_EOI(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  priority_resolver #(.LEVEL_TRIG(1'b0), .AUTO_EOI(1'b1)) u_dut_aeoi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inta(input bit sel, input logic v);
    if (sel) bus2.INTA = v;
    else     bus.INTA  = v;
  endtask

  // Full two-pulse acknowledge, each level held two cycles; snapshots returned.
  task automatic do_ack(input bit sel, output logic [2:0] hp_a, output logic [7:0] isr_a,
                        output logic int_a, output logic p0, output logic p1,
                        output logic p2, output logic [2:0] hp_end, output logic [7:0] isr_end);
    set_inta(sel, 1'b0); tick(); tick();
    hp_a  = sel ? bus2.highestPriority : bus.highestPriority;
    isr_a = sel ? bus2.inService : bus.inService;
    int_a = sel ? bus2.INT : bus.INT;
    p0    = sel ? bus2.currentPulse : bus.currentPulse;
    set_inta(sel, 1'b1); tick(); tick();
    p1    = sel ? bus2.currentPulse : bus.currentPulse;
    set_inta(sel, 1'b0); tick(); tick();
    set_inta(sel, 1'b1); tick(); tick();
    p2      = sel ? bus2.currentPulse : bus.currentPulse;
    hp_end  = sel ? bus2.highestPriority : bus.highestPriority;
    isr_end = sel ? bus2.inService : bus.inService;
  endtask

  task automatic do_eoi(input logic specific, input logic [2:0] lvl);
    bus.EOI = 1'b1; bus.SEOI = specific; bus.EOILevel = lvl;
    tick();
    bus.EOI = 1'b0; bus.SEOI = 1'b0; bus.EOILevel = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %0b want 0", bus.INT); end
    n_tests++; if (bus.highestPriority !== 3'd0) begin n_fail++; $display("FAIL reset_hp: got %0d want 0", bus.highestPriority); end
    n_tests++; if (bus.currentPulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0b want 0", bus.currentPulse); end
    n_tests++; if (bus.requestReg !== 8'h00) begin n_fail++; $display("FAIL reset_irr: got %h want 00", bus.requestReg); end
    n_tests++; if (bus.inService !== 8'h00) begin n_fail++; $display("FAIL reset_isr: got %h want 00", bus.inService); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_edge_ack();
    logic [2:0] hp_a, hp_e; logic [7:0] isr_a, isr_e; logic int_a, p0, p1, p2;
    bus.IR = 8'h20;
    tick();
    n_tests++; if (bus.requestReg !== 8'h20 || bus.INT !== 1'b0) begin n_fail++; $display("FAIL ir5_latch: irr %h int %0b want irr 20 int 0", bus.requestReg, bus.INT); end
    tick();
    n_tests++; if (bus.INT !== 1'b1 || bus.highestPriority !== 3'd5) begin n_fail++; $display("FAIL ir5_int: int %0b hp %0d want 1/5", bus.INT, bus.highestPriority); end
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd5 || isr_a !== 8'h20 || int_a !== 1'b0 || p0 !== 1'b0) begin n_fail++; $display("FAIL ir5_ack1: hp %0d isr %h int %0b pulse %0b want 5/20/0/0", hp_a, isr_a, int_a, p0); end
    n_tests++; if (p1 !== 1'b1 || p2 !== 1'b0) begin n_fail++; $display("FAIL ir5_pulse: mid %0b end %0b want 1/0", p1, p2); end
    n_tests++; if (hp_e !== 3'd5 || isr_e !== 8'h20 || bus.requestReg !== 8'h00) begin n_fail++; $display("FAIL ir5_end: hp %0d isr %h irr %h want 5/20/00", hp_e, isr_e, bus.requestReg); end
    bus.IR = 8'h00;
    do_eoi(1'b0, 3'd0);
    n_tests++; if (bus.inService !== 8'h00) begin n_fail++; $display("FAIL ir5_eoi: isr %h want 00", bus.inService); end
    tick();
  endtask

  task automatic test_fixed_priority();
    logic [2:0] hp_a, hp_e; logic [7:0] isr_a, isr_e; logic int_a, p0, p1, p2;
    bus.IR = 8'h48;
    tick(); tick();
    n_tests++; if (bus.INT !== 1'b1 || bus.highestPriority !== 3'd3) begin n_fail++; $display("FAIL pri_int: int %0b hp %0d want 1/3", bus.INT, bus.highestPriority); end
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd3 || isr_e !== 8'h08 || bus.requestReg !== 8'h40) begin n_fail++; $display("FAIL pri_ack3: hp %0d isr %h irr %h want 3/08/40", hp_a, isr_e, bus.requestReg); end
    tick();
    n_tests++; if (bus.INT !== 1'b0) begin n_fail++; $display("FAIL pri_blocked: int %0b want 0", bus.INT); end
    do_eoi(1'b0, 3'd0);
    n_tests++; if (bus.inService !== 8'h00) begin n_fail++; $display("FAIL pri_eoi: isr %h want 00", bus.inService); end
    tick();
    n_tests++; if (bus.INT !== 1'b1 || bus.highestPriority !== 3'd6) begin n_fail++; $display("FAIL pri_reassert: int %0b hp %0d want 1/6", bus.INT, bus.highestPriority); end
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd6 || isr_e !== 8'h40) begin n_fail++; $display("FAIL pri_ack6: hp %0d isr %h want 6/40", hp_a, isr_e); end
    bus.IR = 8'h00;
    do_eoi(1'b0, 3'd0);
    tick();
  endtask

  task automatic test_nesting();
    logic [2:0] hp_a, hp_e; logic [7:0] isr_a, isr_e; logic int_a, p0, p1, p2;
    bus.IR = 8'h10;
    tick(); tick();
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (isr_e !== 8'h10) begin n_fail++; $display("FAIL nest_ack4: isr %h want 10", isr_e); end
    bus.IR = 8'h50;
    tick(); tick(); tick();
    n_tests++; if (bus.INT !== 1'b0 || bus.requestReg !== 8'h40) begin n_fail++; $display("FAIL nest_low_blocked: int %0b irr %h want 0/40", bus.INT, bus.requestReg); end
    bus.IR = 8'h52;
    tick(); tick();
    n_tests++; if (bus.INT !== 1'b1 || bus.highestPriority !== 3'd1) begin n_fail++; $display("FAIL nest_high_int: int %0b hp %0d want 1/1", bus.INT, bus.highestPriority); end
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd1 || isr_e !== 8'h12) begin n_fail++; $display("FAIL nest_ack1: hp %0d isr %h want 1/12", hp_a, isr_e); end
    do_eoi(1'b1, 3'd4);
    n_tests++; if (bus.inService !== 8'h02) begin n_fail++; $display("FAIL nest_seoi: isr %h want 02", bus.inService); end
    do_eoi(1'b0, 3'd0);
    tick();
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd6 || isr_e !== 8'h40) begin n_fail++; $display("FAIL nest_ack6: hp %0d isr %h want 6/40", hp_a, isr_e); end
    bus.IR = 8'h00;
    do_eoi(1'b0, 3'd0);
    tick();
  endtask

  task automatic test_mask();
    logic [2:0] hp_a, hp_e; logic [7:0] isr_a, isr_e; logic int_a, p0, p1, p2;
    bus.IMR = 8'h04;
    bus.IR  = 8'h04;
    tick(); tick(); tick();
    n_tests++; if (bus.INT !== 1'b0 || bus.requestReg !== 8'h04) begin n_fail++; $display("FAIL mask_hold: int %0b irr %h want 0/04", bus.INT, bus.requestReg); end
    bus.IMR = 8'h00;
    tick();
    n_tests++; if (bus.INT !== 1'b1 || bus.highestPriority !== 3'd2) begin n_fail++; $display("FAIL mask_release: int %0b hp %0d want 1/2", bus.INT, bus.highestPriority); end
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd2 || isr_e !== 8'h04) begin n_fail++; $display("FAIL mask_ack: hp %0d isr %h want 2/04", hp_a, isr_e); end
    bus.IR = 8'h00;
    do_eoi(1'b0, 3'd0);
    tick();
  endtask

  task automatic test_spurious();
    logic [2:0] hp_a, hp_e; logic [7:0] isr_a, isr_e; logic int_a, p0, p1, p2;
    bus.IR = 8'h10;
    tick(); tick();
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    bus.IR = 8'h00;
    tick();
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd7 || isr_a !== 8'h10 || int_a !== 1'b0) begin n_fail++; $display("FAIL spur_ack: hp %0d isr %h int %0b want 7/10/0", hp_a, isr_a, int_a); end
    n_tests++; if (hp_e !== 3'd7 || isr_e !== 8'h10 || p1 !== 1'b1) begin n_fail++; $display("FAIL spur_end: hp %0d isr %h pulse %0b want 7/10/1", hp_e, isr_e, p1); end
    do_eoi(1'b0, 3'd0);
    tick();

    bus2.IR = 8'h01;
    tick(); tick();
    n_tests++; if (bus2.INT !== 1'b1) begin n_fail++; $display("FAIL aeoi_int: int %0b want 1", bus2.INT); end
    do_ack(1'b1, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd0 || isr_a !== 8'h01 || p1 !== 1'b1) begin n_fail++; $display("FAIL aeoi_ack: hp %0d isr %h pulse %0b want 0/01/1", hp_a, isr_a, p1); end
    n_tests++; if (isr_e !== 8'h00 || p2 !== 1'b0) begin n_fail++; $display("FAIL aeoi_clear: isr %h pulse %0b want 00/0", isr_e, p2); end
    bus2.IR = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [2:0] hp_a, hp_e; logic [7:0] isr_a, isr_e; logic int_a, p0, p1, p2;
    bus.IR = 8'h08;
    tick(); tick();
    bus.INTA = 1'b0; tick(); tick();
    bus.INTA = 1'b1; tick(); tick();
    n_tests++; if (bus.currentPulse !== 1'b1 || bus.inService !== 8'h08) begin n_fail++; $display("FAIL gap_state: pulse %0b isr %h want 1/08", bus.currentPulse, bus.inService); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.INT !== 1'b0 || bus.highestPriority !== 3'd0 || bus.currentPulse !== 1'b0 ||
                   bus.requestReg !== 8'h00 || bus.inService !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: int %0b hp %0d pulse %0b irr %h isr %h want all 0",
               bus.INT, bus.highestPriority, bus.currentPulse, bus.requestReg, bus.inService);
    end
    bus.IR = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    bus.IR = 8'h80;
    tick(); tick();
    n_tests++; if (bus.INT !== 1'b1 || bus.highestPriority !== 3'd7) begin n_fail++; $display("FAIL post_reset_int: int %0b hp %0d want 1/7", bus.INT, bus.highestPriority); end
    do_ack(1'b0, hp_a, isr_a, int_a, p0, p1, p2, hp_e, isr_e);
    n_tests++; if (hp_a !== 3'd7 || isr_e !== 8'h80 || p1 !== 1'b1 || p2 !== 1'b0) begin n_fail++; $display("FAIL post_reset_ack: hp %0d isr %h pulse %0b/%0b want 7/80/1/0", hp_a, isr_e, p1, p2); end
    bus.IR = 8'h00;
    do_eoi(1'b0, 3'd0);
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.IR  = 8'h00; bus.IMR  = 8'h00; bus.INTA  = 1'b1; bus.EOI  = 1'b0; bus.SEOI  = 1'b0; bus.EOILevel  = 3'd0;
    bus2.IR = 8'h00; bus2.IMR = 8'h00; bus2.INTA = 1'b1; bus2.EOI = 1'b0; bus2.SEOI = 1'b0; bus2.EOILevel = 3'd0;
    test_reset();
    test_edge_ack();
    test_fixed_priority();
    test_nesting();
    test_mask();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
